// File: rtl/gb_cpu_common_pkg.sv
// Shared gb_cpu definitions: interrupt FSM states, interrupt source
// indices, interrupt register selects and an index-width helper.
package gb_cpu_common_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT0   = 3'd1,
    WAIT1   = 3'd2,
    PUSH_HI = 3'd3,
    PUSH_LO = 3'd4,
    JUMP    = 3'd5
  } irq_state_t;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  localparam logic REG_SEL_IF = 1'b0;
  localparam logic REG_SEL_IE = 1'b1;

  // Width of an index into n sources; never narrower than one bit.
  function automatic int irq_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gb_irq_prio_enc.sv
// Priority encoder for interrupt requests: bit 0 wins. valid is low
// when no request bit is set, in which case idx is 0.
module gb_irq_prio_enc
  import gb_cpu_common_pkg::*;
#(
  parameter int NUM_IRQ = 5,
  parameter int IDX_W   = irq_idx_w(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gb_irq_ctrl.sv
// gb_cpu interrupt controller: IME/IE/IF ownership, delayed EI,
// priority selection and the 5 M-cycle dispatch sequence.
// Optional build macro GB_IRQ_HALT_BUG_EN adds halt_bug_o.
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | no dispatch; watching for IME & pending IRQ
// WAIT0   | dispatch cycle 1, internal delay
// WAIT1   | dispatch cycle 2, internal delay
// PUSH_HI | core pushes PC[15:8]
// PUSH_LO | core pushes PC[7:0]; vector chosen, IF bit cleared
// JUMP    | core loads vector_o into PC
module gb_irq_ctrl
  import gb_cpu_common_pkg::*;
#(
  parameter int          NUM_IRQ       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int          VECTOR_STRIDE = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_req_i,
  input  logic               reg_wr_i,
  input  logic               reg_sel_i,
  input  logic [7:0]         reg_wdata_i,
  output logic [7:0]         reg_rdata_o,
  input  logic               ei_i,
  input  logic               di_i,
  input  logic               reti_i,
  input  logic               instr_boundary_i,
  input  logic               halted_i,
  output logic               ime_o,
  output logic               wake_o,
  output logic               dispatch_o,
  output logic               push_hi_o,
  output logic               push_lo_o,
  output logic               jump_o,
  output logic [15:0]        vector_o
`ifdef GB_IRQ_HALT_BUG_EN
  ,
  output logic               halt_bug_o
`endif
);

  localparam int IDX_W = irq_idx_w(NUM_IRQ);

  irq_state_t         state_q, state_d;
  logic               ime_q, ime_d;
  logic               ei_pend_q, ei_pend_d;
  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [NUM_IRQ-1:0] ie_q, ie_d;
  logic [NUM_IRQ-1:0] pending;
  logic [15:0]        vector_q, vector_d;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_valid;
  logic               dispatch_start;

  // Upper write-data bits only matter when all eight sources exist, and
  // halted_i only feeds the optional halt-bug detector.
  logic unused_inputs;
  assign unused_inputs = ^{reg_wdata_i, halted_i};

  assign pending        = ie_q & if_q;
  assign wake_o         = |pending;
  assign ime_o          = ime_q;
  assign dispatch_start = ime_q & wake_o & instr_boundary_i & (state_q == IDLE);

  // Selection is sampled in PUSH_LO, so an IE write from the stack push
  // in PUSH_HI can cancel the dispatch.
  gb_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .req   (pending),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Dispatch sequencer next state and decoded strobes.
  always_comb begin
    state_d    = state_q;
    dispatch_o = 1'b0;
    push_hi_o  = 1'b0;
    push_lo_o  = 1'b0;
    jump_o     = 1'b0;
    vector_o   = 16'h0000;
    unique case (state_q)
      IDLE:    if (dispatch_start) state_d = WAIT0;
      WAIT0:   begin state_d = WAIT1;   dispatch_o = 1'b1; end
      WAIT1:   begin state_d = PUSH_HI; dispatch_o = 1'b1; end
      PUSH_HI: begin state_d = PUSH_LO; dispatch_o = 1'b1; push_hi_o = 1'b1; end
      PUSH_LO: begin state_d = JUMP;    dispatch_o = 1'b1; push_lo_o = 1'b1; end
      JUMP: begin
        state_d    = IDLE;
        dispatch_o = 1'b1;
        jump_o     = 1'b1;
        vector_o   = vector_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // IME and the delayed-EI flag; instruction controls are ignored mid-dispatch.
  always_comb begin
    ime_d     = ime_q;
    ei_pend_d = ei_pend_q;
    if (state_q == IDLE) begin
      if (ei_pend_q && instr_boundary_i) begin
        ime_d     = 1'b1;
        ei_pend_d = 1'b0;
      end
      if (ei_i)   ei_pend_d = 1'b1;
      if (reti_i) ime_d = 1'b1;
      if (di_i) begin
        ime_d     = 1'b0;
        ei_pend_d = 1'b0;
      end
      if (dispatch_start) ime_d = 1'b0;
    end
  end

  // IF/IE updates: dispatch acknowledge, then CPU write, then new requests on top.
  always_comb begin
    if_d = if_q;
    ie_d = ie_q;
    if (state_q == PUSH_LO && enc_valid) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (enc_idx == IDX_W'(i)) if_d[i] = 1'b0;
      end
    end
    if (reg_wr_i && reg_sel_i == REG_SEL_IF) if_d = reg_wdata_i[NUM_IRQ-1:0];
    if (reg_wr_i && reg_sel_i == REG_SEL_IE) ie_d = reg_wdata_i[NUM_IRQ-1:0];
    if_d = if_d | irq_req_i;
  end

  // Vector latched in PUSH_LO for presentation during JUMP.
  always_comb begin
    vector_d = vector_q;
    if (state_q == PUSH_LO) begin
      vector_d = enc_valid ? (VECTOR_BASE + 16'(enc_idx) * 16'(VECTOR_STRIDE)) : 16'h0000;
    end
  end

  // Register readback: unimplemented IF bits read 1, unimplemented IE bits read 0.
  always_comb begin
    reg_rdata_o = (reg_sel_i == REG_SEL_IE) ? 8'h00 : 8'hFF;
    for (int i = 0; i < NUM_IRQ; i++) begin
      reg_rdata_o[i] = (reg_sel_i == REG_SEL_IE) ? ie_q[i] : if_q[i];
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ime_q     <= 1'b0;
      ei_pend_q <= 1'b0;
      if_q      <= '0;
      ie_q      <= '0;
      vector_q  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      ime_q     <= ime_d;
      ei_pend_q <= ei_pend_d;
      if_q      <= if_d;
      ie_q      <= ie_d;
      vector_q  <= vector_d;
    end
  end

`ifdef GB_IRQ_HALT_BUG_EN
  logic halted_q;

  // One-cycle pulse when HALT is entered with IME off and an IRQ already pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      halted_q   <= 1'b0;
      halt_bug_o <= 1'b0;
    end else begin
      halted_q   <= halted_i;
      halt_bug_o <= halted_i & ~halted_q & ~ime_q & wake_o;
    end
  end
`endif

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// Self-checking bench for gb_irq_ctrl (default build, NUM_IRQ = 5).
module tb_gb_irq_ctrl;

  localparam int NUM_IRQ = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_IRQ-1:0] irq_req_i;
  logic               reg_wr_i;
  logic               reg_sel_i;
  logic [7:0]         reg_wdata_i;
  logic [7:0]         reg_rdata_o;
  logic               ei_i, di_i, reti_i;
  logic               instr_boundary_i;
  logic               halted_i;
  logic               ime_o, wake_o, dispatch_o;
  logic               push_hi_o, push_lo_o, jump_o;
  logic [15:0]        vector_o;
`ifdef GB_IRQ_HALT_BUG_EN
  logic               halt_bug_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  gb_irq_ctrl #(
    .NUM_IRQ       (NUM_IRQ),
    .VECTOR_BASE   (16'h0040),
    .VECTOR_STRIDE (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .irq_req_i        (irq_req_i),
    .reg_wr_i         (reg_wr_i),
    .reg_sel_i        (reg_sel_i),
    .reg_wdata_i      (reg_wdata_i),
    .reg_rdata_o      (reg_rdata_o),
    .ei_i             (ei_i),
    .di_i             (di_i),
    .reti_i           (reti_i),
    .instr_boundary_i (instr_boundary_i),
    .halted_i         (halted_i),
    .ime_o            (ime_o),
    .wake_o           (wake_o),
    .dispatch_o       (dispatch_o),
    .push_hi_o        (push_hi_o),
    .push_lo_o        (push_lo_o),
    .jump_o           (jump_o),
    .vector_o         (vector_o)
`ifdef GB_IRQ_HALT_BUG_EN
    ,
    .halt_bug_o       (halt_bug_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, obs, e);
    end
  endtask

  task automatic sb_now(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    sb_push(tag, exp);
    sb_pop(obs);
  endtask

  // {dispatch, push_hi, push_lo, jump, vector}
  function automatic logic [31:0] strobes();
    return {12'd0, dispatch_o, push_hi_o, push_lo_o, jump_o, vector_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    irq_req_i        = '0;
    reg_wr_i         = 1'b0;
    reg_sel_i        = 1'b0;
    reg_wdata_i      = 8'h00;
    ei_i             = 1'b0;
    di_i             = 1'b0;
    reti_i           = 1'b0;
    instr_boundary_i = 1'b0;
    halted_i         = 1'b0;
  endtask

  task automatic read_reg(input logic sel, input logic [7:0] exp, input string tag);
    reg_sel_i = sel;
    #1;
    sb_now(tag, 32'(reg_rdata_o), 32'(exp));
    reg_sel_i = 1'b0;
  endtask

  task automatic write_reg(input logic sel, input logic [7:0] data);
    reg_wr_i    = 1'b1;
    reg_sel_i   = sel;
    reg_wdata_i = data;
  endtask

  // Called in WAIT0; walks WAIT0..JUMP and the following IDLE cycle.
  task automatic run_dispatch(input string name, input logic [15:0] vec, input bit cancel);
    sb_push({name, "_wait0"},   32'h0008_0000);
    sb_push({name, "_wait1"},   32'h0008_0000);
    sb_push({name, "_push_hi"}, 32'h000C_0000);
    sb_push({name, "_push_lo"}, 32'h000A_0000);
    sb_push({name, "_jump"},    32'h0009_0000 | 32'(vec));
    sb_push({name, "_idle"},    32'h0000_0000);
    for (int i = 0; i < 6; i++) begin
      idle_in();
      if (cancel && i == 2) write_reg(1'b1, 8'h00);
      #1;
      sb_pop(strobes());
      tick();
    end
    idle_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached without finish, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle_in();
    #3;
    // reset state
    sb_push("rst_strobes", 32'h0);
    sb_push("rst_ime", 32'h0);
    sb_push("rst_wake", 32'h0);
    sb_pop(strobes());
    sb_pop(32'(ime_o));
    sb_pop(32'(wake_o));
    read_reg(1'b0, 8'hE0, "rst_if");
    read_reg(1'b1, 8'h00, "rst_ie");
    @(negedge clk);
    reset = 1'b1;
    tick();

    // EI delay: EI cycle's own boundary ignored, next boundary enables IME
    write_reg(1'b1, 8'h01); tick(); idle_in();
    write_reg(1'b0, 8'h01); tick(); idle_in();
    sb_now("ei_wake", 32'(wake_o), 32'h1);
    ei_i = 1'b1; instr_boundary_i = 1'b1;
    tick(); idle_in();
    sb_now("ei_ime_t1", 32'(ime_o), 32'h0);
    tick(); idle_in();
    sb_now("ei_ime_t2", 32'(ime_o), 32'h0);
    tick(); idle_in();
    instr_boundary_i = 1'b1;
    sb_now("ei_ime_t3", 32'(ime_o), 32'h0);
    tick(); idle_in();
    instr_boundary_i = 1'b1;
    sb_now("ei_ime_t4", 32'(ime_o), 32'h1);
    sb_now("ei_nodisp_t4", 32'(dispatch_o), 32'h0);
    tick(); idle_in();
    run_dispatch("ei", 16'h0040, 1'b0);
    sb_now("ei_ime_after", 32'(ime_o), 32'h0);
    read_reg(1'b0, 8'hE0, "ei_if_after");

    // Priority: sources 2 and 4 together, source 2 wins
    reti_i = 1'b1; write_reg(1'b1, 8'h1F);
    tick(); idle_in();
    sb_now("pri_ime", 32'(ime_o), 32'h1);
    irq_req_i = 5'b10100; instr_boundary_i = 1'b1;
    #1;
    sb_now("pri_wake_pre", 32'(wake_o), 32'h0);
    tick(); idle_in();
    instr_boundary_i = 1'b1;
    sb_now("pri_wake", 32'(wake_o), 32'h1);
    tick(); idle_in();
    run_dispatch("pri", 16'h0050, 1'b0);
    read_reg(1'b0, 8'hF0, "pri_if_after");
    sb_now("pri_ime_after", 32'(ime_o), 32'h0);
    sb_now("pri_wake_after", 32'(wake_o), 32'h1);

    // Cancellation: IE cleared during PUSH_HI leaves vector 0000
    write_reg(1'b1, 8'h04); tick(); idle_in();
    write_reg(1'b0, 8'h04); reti_i = 1'b1; tick(); idle_in();
    sb_now("can_ime", 32'(ime_o), 32'h1);
    instr_boundary_i = 1'b1;
    tick(); idle_in();
    run_dispatch("can", 16'h0000, 1'b1);
    read_reg(1'b0, 8'hE4, "can_if_after");
    read_reg(1'b1, 8'h00, "can_ie_after");

    // Write/request collision and unimplemented register bits
    write_reg(1'b0, 8'h00); irq_req_i = 5'b00001;
    tick(); idle_in();
    read_reg(1'b0, 8'hE1, "col_if");
    write_reg(1'b1, 8'hFF); tick(); idle_in();
    read_reg(1'b1, 8'h1F, "ie_upper_bits");
    write_reg(1'b0, 8'hFF); tick(); idle_in();
    read_reg(1'b0, 8'hFF, "if_upper_bits");

    // DI after EI, before any boundary: IME never rises
    write_reg(1'b1, 8'h01); tick(); idle_in();
    ei_i = 1'b1; tick(); idle_in();
    di_i = 1'b1; tick(); idle_in();
    for (int i = 0; i < 3; i++) begin
      instr_boundary_i = 1'b1;
      sb_now($sformatf("di_ime_%0d", i), 32'(ime_o), 32'h0);
      sb_now($sformatf("di_disp_%0d", i), 32'(dispatch_o), 32'h0);
      tick(); idle_in();
    end
    sb_now("di_disp_end", 32'(dispatch_o), 32'h0);
    sb_now("di_wake", 32'(wake_o), 32'h1);

    // Reset asserted in WAIT1
    reti_i = 1'b1; tick(); idle_in();
    instr_boundary_i = 1'b1; tick(); idle_in();
    tick();
    sb_now("rstd_wait1", strobes(), 32'h0008_0000);
    reset = 1'b0;
    #1;
    sb_now("rstd_strobes", strobes(), 32'h0);
    read_reg(1'b0, 8'hE0, "rstd_if");
    read_reg(1'b1, 8'h00, "rstd_ie");
    sb_now("rstd_ime", 32'(ime_o), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    sb_now("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gb_irq_ctrl.md
Name: gb_irq_ctrl

Overview:
- Parametrised interrupt controller for the gb_cpu core.
- Owns the IME, IE and IF state and applies the one-instruction EI delay.
- Priority-encodes pending requests and runs the 5 M-cycle dispatch sequence.
- Tells the core when to push PC and which vector to jump to. Sits between the peripheral request lines and the gb_cpu scheduler; generalises the core's single delayed enable flop.

Parameters:
- NUM_IRQ, 5: number of interrupt sources. Legal range 1..8. Bit 0 has the highest priority.
- VECTOR_BASE, 16'h0040: vector of source 0.
- VECTOR_STRIDE, 8: address step between consecutive vectors.

Ports:
- clk  in  1: machine (M) clock.
- reset  in  1: asynchronous, active-low reset.
- irq_req_i  in  NUM_IRQ: per-source request pulses. Each sets its IF bit.
- reg_wr_i  in  1: register write strobe.
- reg_sel_i  in  1: register select. 0 = IF, 1 = IE.
- reg_wdata_i  in  8: write data.
- reg_rdata_o  out  8: read data for the selected register.
- ei_i  in  1: EI executed this cycle.
- di_i  in  1: DI executed this cycle.
- reti_i  in  1: RETI executed this cycle.
- instr_boundary_i  in  1: current M-cycle is the last cycle of an instruction.
- halted_i  in  1: core is in HALT.
- ime_o  out  1: interrupt master enable.
- wake_o  out  1: some (IE & IF) bit is set, regardless of IME.
- dispatch_o  out  1: a dispatch sequence is in progress.
- push_hi_o  out  1: core must push PC[15:8] this cycle.
- push_lo_o  out  1: core must push PC[7:0] this cycle.
- jump_o  out  1: core must load vector_o into PC this cycle.
- vector_o  out  16: dispatch target. Valid while jump_o is high.

Behaviour:
- Reset state: IME=0, ei_pending=0, IF=0, IE=0, FSM=IDLE. Every output is 0, except reg_rdata_o, which follows the read rules below.
- Register reads are combinational.
  - IF: bits [NUM_IRQ-1:0] are the IF bits; bits above NUM_IRQ read 1.
  - IE: bits above NUM_IRQ read 0.
- Register writes take effect at the next clock edge.
- Simultaneous irq_req_i and IF write in the same cycle: IF_next = wdata | req. The request wins.
- EI: sets ei_pending. IME becomes 1 on the edge after the next instruction_boundary that occurs after the EI cycle. The EI instruction's own boundary does not count.
- DI: clears IME and ei_pending immediately, and wins over a pending EI.
- RETI: sets IME=1 at the next edge, with no delay.
- Dispatch condition: IME & |(IE & IF) & instr_boundary_i & FSM==IDLE. When it holds:
  - IME is cleared at the next edge.
  - The FSM enters WAIT0.
- FSM sequence: IDLE -> WAIT0 -> WAIT1 -> PUSH_HI -> PUSH_LO -> JUMP -> IDLE. One M-cycle per state; dispatch_o is high in every non-IDLE state.
- Strobes: push_hi_o is high in PUSH_HI, push_lo_o in PUSH_LO, jump_o in JUMP.
- Vector selection: in PUSH_LO, the highest-priority set bit of (IE & IF) is selected, which models cancellation by a stack write to IE.
  - That bit's IF bit is cleared.
  - vector_o = VECTOR_BASE + index*VECTOR_STRIDE, registered for JUMP.
  - If no bit is set, vector_o = 16'h0000 and no IF bit is cleared.
- During dispatch, ei_i/di_i/reti_i are ignored. The core does not issue them then.
- halted_i with wake_o high: wake_o is the core's exit signal. Dispatch still waits for instr_boundary_i.
- Reset asserted mid-dispatch: the FSM returns to IDLE asynchronously and all strobes drop immediately.

Optional Feature:
- Macro: GB_IRQ_HALT_BUG_EN.
- When defined: adds output halt_bug_o, 1 bit, reset 0.
  - It pulses high for one cycle when halted_i rises while IME=0 and wake_o=1.
  - The core uses it to suppress the next PC increment.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package gb_cpu_common_pkg gains:
  - irq_state_t enum: IDLE, WAIT0, WAIT1, PUSH_HI, PUSH_LO, JUMP.
  - Constants IRQ_VBLANK..IRQ_JOYPAD, indices 0..4.
  - Constants REG_SEL_IF / REG_SEL_IE.
- One natural sub-module: gb_irq_prio_enc, a parametrised NUM_IRQ-wide priority encoder that outputs the index and a valid bit.

Test Plan:
- EI delay: IE=01, IF=01, pulse ei_i, then boundaries at cycles t and t+3 -> ime_o=1 after the t+3 boundary edge; dispatch_o rises one cycle later.
- Priority: IME=1, IE=1F, req 5'b10100 at a boundary -> push_hi_o at dispatch cycle 3, push_lo_o at cycle 4, jump_o at cycle 5 with vector_o=16'h0050; IF reads E0|5'b10000=F0.
- Cancellation: IE=04, IF=04, IE write 00 during PUSH_HI -> vector_o=16'h0000 at JUMP; IF still reads E4.
- Write/request collision: write IF=00 while irq_req_i=5'b00001 -> IF reads E1.
- DI vs pending EI: ei_i, then di_i before the boundary -> ime_o stays 0 and no dispatch occurs with IE&IF nonzero.
- Reset mid-dispatch: assert reset in WAIT1 -> dispatch_o, push_*_o and jump_o are 0 in the same cycle; IF reads E0 and IE reads 00.
